// File: rtl/chinpo_pkg.sv
// Shared definitions for the CHINPO interrupt controller: FSM encoding,
// vector defaults and the vector address helper.
package chinpo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } int_state_t;

    localparam logic [15:0] VEC_BASE_DEFAULT  = 16'h0100;
    localparam int          VEC_SHIFT_DEFAULT = 2;
    localparam int          INT_ID_W          = 3;

    // Id is widened to 16 bits before shifting so high bits are not lost early.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input int shift,
                                             input logic [INT_ID_W-1:0] id);
        logic [15:0] id_ext;
        id_ext = {{(16-INT_ID_W){1'b0}}, id};
        return base + (id_ext << shift);
    endfunction

endpackage

// File: rtl/chinpo_irq_sync.sv
// Two-flop synchronizer plus rising-edge detector for one interrupt pin.
module chinpo_irq_sync (
    input  logic CLK,
    input  logic Reset,
    input  logic irq_async,
    output logic irq_edge
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Cleared on reset so a pin held high across release reads as a new edge.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= irq_async;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign irq_edge = sync2_reg & ~prev_reg;

endmodule

// File: rtl/chinpo_interrupt_controller.sv
// Latches, masks and prioritises interrupt edges, then handshakes a single
// grant with the control unit through Int / IntAck / Eoi.
module chinpo_interrupt_controller
    import chinpo_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter logic [15:0] VEC_BASE  = VEC_BASE_DEFAULT,
    parameter int          VEC_SHIFT = VEC_SHIFT_DEFAULT
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [NUM_SRC-1:0]  IrqIn,
    input  logic                MaskWr,
    input  logic [NUM_SRC-1:0]  MaskData,
    input  logic                IntAck,
    input  logic                Eoi,
    output logic                Int,
    output logic [15:0]         VecAddr,
    output logic [INT_ID_W-1:0] IntId,
    output logic [NUM_SRC-1:0]  Pending,
    output logic                InService
);

    int_state_t            state_reg;
    logic                  int_reg;
    logic                  in_service_reg;
    logic [INT_ID_W-1:0]   int_id_reg;
    logic [15:0]           vec_addr_reg;
    logic [NUM_SRC-1:0]    mask_reg;
    logic [NUM_SRC-1:0]    pending_reg;
    logic [NUM_SRC-1:0]    pending_next;
    logic [NUM_SRC-1:0]    ack_clear;
    logic [NUM_SRC-1:0]    irq_edge_vec;
    logic [NUM_SRC-1:0]    cand;
    logic [INT_ID_W-1:0]   win_id;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            chinpo_irq_sync u_sync (
                .CLK       (CLK),
                .Reset     (Reset),
                .irq_async (IrqIn[gi]),
                .irq_edge  (irq_edge_vec[gi])
            );
        end
    endgenerate

    // A fresh edge wins over the acknowledge clear of the same source.
    always_comb begin
        ack_clear = '0;
        if (state_reg == ST_REQ && IntAck)
            ack_clear = NUM_SRC'(1) << int_id_reg;
        pending_next = (pending_reg & ~ack_clear) | irq_edge_vec;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mask_reg    <= '0;
            pending_reg <= '0;
        end else begin
            if (MaskWr)
                mask_reg <= MaskData;
            pending_reg <= pending_next;
        end
    end

    assign cand = pending_reg & mask_reg;

    // Scan downwards so the lowest set index is the last assignment.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i])
                win_id = INT_ID_W'(i);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            int_reg        <= 1'b0;
            in_service_reg <= 1'b0;
            int_id_reg     <= '0;
            vec_addr_reg   <= VEC_BASE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|cand) begin
                        int_id_reg   <= win_id;
                        vec_addr_reg <= vec_addr(VEC_BASE, VEC_SHIFT, win_id);
                        int_reg      <= 1'b1;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (IntAck) begin
                        int_reg        <= 1'b0;
                        in_service_reg <= 1'b1;
                        state_reg      <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (Eoi) begin
                        in_service_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    int_reg        <= 1'b0;
                    in_service_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    assign Int       = int_reg;
    assign InService = in_service_reg;
    assign IntId     = int_id_reg;
    assign VecAddr   = vec_addr_reg;
    assign Pending   = pending_reg;

endmodule
